// File: rtl/cmd_link_pkg.sv
// rtl/cmd_link_pkg.sv - shared types and constants for the remote command link
package cmd_link_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    localparam logic [7:0] RESP_ACK         = 8'hA5;
    localparam int         DEFAULT_BAUD_DIV = 5208;
    localparam int         DEFAULT_BYTE_TMO = 1_000_000;
endpackage

// File: rtl/cmd_uart_responder_if.sv
// rtl/cmd_uart_responder_if.sv - command/response handshake between responder and command processor
interface cmd_uart_responder_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    modport slave  (output cmd, output cmd_rdy, output tx_done,
                    input  clr_cmd_rdy, input resp, input trmt);
    modport master (input  cmd, input cmd_rdy, input tx_done,
                    output clr_cmd_rdy, output resp, output trmt);
endinterface

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 byte serialiser with completion flag
module uart_byte_tx
    import cmd_link_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] resp,
    input  logic       trmt,
    output logic       TX,
    output logic       tx_done
);
    localparam int            BW        = $clog2(BAUD_DIV) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    tx_state_t     r_state, w_next;
    logic [9:0]    r_shift;
    logic [BW-1:0] r_baud_cnt;
    logic [3:0]    r_bit_cnt;
    logic          r_tx_done;
    logic          w_load, w_shift, w_last;

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            TX_IDLE: if (trmt) begin
                w_load = 1'b1;
                w_next = TX_BUSY;
            end
            TX_BUSY: if (r_baud_cnt == BAUD_LAST) begin
                w_shift = 1'b1;
                if (r_bit_cnt == 4'd9) begin
                    w_last = 1'b1;
                    w_next = TX_IDLE;
                end
            end
            default: w_next = TX_IDLE;
        endcase
    end

    // Ones are shifted in behind the frame so the line rests high once the stop bit is out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= TX_IDLE;
            r_shift    <= '1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_shift    <= {1'b1, resp, 1'b0};
                r_baud_cnt <= '0;
                r_bit_cnt  <= '0;
                r_tx_done  <= 1'b0;
            end else if (w_shift) begin
                r_shift    <= {1'b1, r_shift[9:1]};
                r_baud_cnt <= '0;
                r_bit_cnt  <= w_last ? 4'd0 : r_bit_cnt + 4'd1;
                if (w_last) r_tx_done <= 1'b1;
            end else if (r_state == TX_BUSY) begin
                r_baud_cnt <= r_baud_cnt + BW'(1);
            end
        end
    end

    assign TX      = r_shift[0];
    assign tx_done = r_tx_done;
endmodule

// File: rtl/cmd_uart_responder.sv
// rtl/cmd_uart_responder.sv - UART receiver, 16-bit command assembly and response transmitter
module cmd_uart_responder
    import cmd_link_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int BYTE_TMO = DEFAULT_BYTE_TMO
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX,
    output logic                  TX,
    output logic                  frm_err,
    cmd_uart_responder_if.slave   bus
);
    localparam int            BW        = $clog2(BAUD_DIV) + 1;
    localparam int            TW        = $clog2(BYTE_TMO) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(BYTE_TMO - 1);

    logic          r_rx_s1, r_rx_s2, r_rx_prev;
    rx_state_t     r_rx_state, w_rx_next;
    logic [BW-1:0] r_rx_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_rx_shift;
    logic          r_byte_vld, r_frm_err;
    logic          w_fall, w_half, w_full;

    asm_state_t    r_asm_state, w_asm_next;
    logic [TW-1:0] r_tmo_cnt;
    logic [7:0]    r_hi_byte;
    logic [15:0]   r_cmd;
    logic          r_cmd_rdy;
    logic          w_take_hi, w_take_lo;

    assign w_fall = r_rx_prev & ~r_rx_s2;
    assign w_half = (r_rx_cnt == HALF_LAST);
    assign w_full = (r_rx_cnt == BAUD_LAST);

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            IDLE:    if (w_fall) w_rx_next = START;
            START:   if (w_half) w_rx_next = r_rx_s2 ? IDLE : DATA;
            DATA:    if (w_full && r_bit_cnt == 3'd7) w_rx_next = STOP;
            STOP:    if (w_full) w_rx_next = IDLE;
            default: w_rx_next = IDLE;
        endcase
    end

    // The baud counter restarts at every sample so all later samples stay mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_byte_vld <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_rx_s1    <= RX;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_next;
            r_byte_vld <= 1'b0;
            r_frm_err  <= 1'b0;
            if (r_rx_state == IDLE || (r_rx_state == START && w_half) || w_full)
                r_rx_cnt <= '0;
            else
                r_rx_cnt <= r_rx_cnt + BW'(1);
            if (r_rx_state == IDLE)
                r_bit_cnt <= '0;
            else if (r_rx_state == DATA && w_full) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            if (r_rx_state == STOP && w_full) begin
                r_byte_vld <= r_rx_s2;
                r_frm_err  <= ~r_rx_s2;
            end
        end
    end

    always_comb begin
        w_asm_next = r_asm_state;
        w_take_hi  = 1'b0;
        w_take_lo  = 1'b0;
        if (r_frm_err)
            w_asm_next = WAIT_HI;
        else begin
            case (r_asm_state)
                WAIT_HI: if (r_byte_vld) begin
                    w_take_hi  = 1'b1;
                    w_asm_next = WAIT_LO;
                end
                WAIT_LO: if (r_byte_vld) begin
                    w_take_lo  = 1'b1;
                    w_asm_next = WAIT_HI;
                end else if (r_tmo_cnt == TMO_LAST)
                    w_asm_next = WAIT_HI;
                default: w_asm_next = WAIT_HI;
            endcase
        end
    end

    // A new command outranks a clear arriving on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm_state <= WAIT_HI;
            r_tmo_cnt   <= '0;
            r_hi_byte   <= '0;
            r_cmd       <= '0;
            r_cmd_rdy   <= 1'b0;
        end else begin
            r_asm_state <= w_asm_next;
            if (w_take_hi) begin
                r_tmo_cnt <= '0;
                r_hi_byte <= r_rx_shift;
            end else if (r_asm_state == WAIT_LO)
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (w_take_lo) r_cmd <= {r_hi_byte, r_rx_shift};
            if (w_take_lo)
                r_cmd_rdy <= 1'b1;
            else if (w_take_hi || bus.clr_cmd_rdy)
                r_cmd_rdy <= 1'b0;
        end
    end

    uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .resp    (bus.resp),
        .trmt    (bus.trmt),
        .TX      (TX),
        .tx_done (bus.tx_done)
    );

    assign bus.cmd     = r_cmd;
    assign bus.cmd_rdy = r_cmd_rdy;
    assign frm_err     = r_frm_err;
endmodule

// File: tb/tb_cmd_uart_responder.sv
// tb/tb_cmd_uart_responder.sv - self-checking bench for cmd_uart_responder
module tb_cmd_uart_responder;
    import cmd_link_pkg::*;

    localparam int BIT = 16;

    logic clk = 1'b0;
    logic rst, RX, TX, frm_err;
    cmd_uart_responder_if bus();

    cmd_uart_responder #(.BAUD_DIV(BIT), .BYTE_TMO(400)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .frm_err(frm_err), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rises = 0;
    int frm_cnt = 0;
    logic prev_rdy = 1'b0;
    time t_rise = 0;
    time t_start = 0;

    always @(negedge clk) begin
        prev_rdy <= bus.cmd_rdy;
        if (bus.cmd_rdy && !prev_rdy) begin
            rises  <= rises + 1;
            t_rise <= $time;
        end
        if (frm_err) frm_cnt <= frm_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        t_start = $time;
        RX = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (BIT) @(negedge clk);
        end
        RX = stop;
        repeat (BIT) @(negedge clk);
        RX = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic tx_check(input logic [7:0] d, input bit with_ignored);
        logic [9:0] frame;
        int bad_lvl;
        frame = {1'b1, d, 1'b0};
        bad_lvl = 0;
        bus.resp = d;
        bus.trmt = 1'b1;
        @(negedge clk);
        bus.trmt = 1'b0;
        for (int k = 0; k < 10 * BIT; k++) begin
            if (k == 0) chk("tx_done_cleared", 32'(bus.tx_done), 32'd0);
            if (TX !== frame[k / BIT]) bad_lvl++;
            if (with_ignored && k == 40) begin
                bus.resp = 8'hFF;
                bus.trmt = 1'b1;
            end
            if (with_ignored && k == 41) bus.trmt = 1'b0;
            if (k == 10 * BIT - 1) chk("tx_done_early", 32'(bus.tx_done), 32'd0);
            @(negedge clk);
        end
        chk("tx_levels", 32'(bad_lvl), 32'd0);
        chk("tx_done_set", 32'(bus.tx_done), 32'd1);
        chk("tx_idle_high", 32'(TX), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int          gap;
        logic [15:0] exp_cmd;
        logic        exp_rdy;
        int          exp_frm;
        int          exp_rises;
    } vec_t;

    vec_t vecs[10];

    logic        pending, exp_rdy, bad, big, do_tx, ok;
    logic [7:0]  pend_b, b, txb;
    logic [15:0] exp_cmd;
    int          exp_frm, exp_rises, frm_base, rise_base, gap, lat, prev_rises;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h43, 1'b1, 20,  16'h0000, 1'b0, 0, 0};
        vecs[1] = '{8'hF2, 1'b1, 0,   16'h43F2, 1'b1, 0, 1};
        vecs[2] = '{8'h12, 1'b1, 30,  16'h43F2, 1'b0, 0, 1};
        vecs[3] = '{8'h34, 1'b1, 500, 16'h43F2, 1'b0, 0, 1};
        vecs[4] = '{8'h56, 1'b1, 0,   16'h3456, 1'b1, 0, 2};
        vecs[5] = '{8'h77, 1'b0, 10,  16'h3456, 1'b1, 1, 2};
        vecs[6] = '{8'h9C, 1'b1, 10,  16'h3456, 1'b0, 1, 2};
        vecs[7] = '{8'h11, 1'b0, 10,  16'h3456, 1'b0, 2, 2};
        vecs[8] = '{8'hAB, 1'b1, 10,  16'h3456, 1'b0, 2, 2};
        vecs[9] = '{8'hCD, 1'b1, 0,   16'hABCD, 1'b1, 2, 3};

        rst = 1'b1; RX = 1'b1;
        bus.clr_cmd_rdy = 1'b0; bus.trmt = 1'b0; bus.resp = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_TX", 32'(TX), 32'd1);
        chk("rst_cmd", 32'(bus.cmd), 32'd0);
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("rst_tx_done", 32'(bus.tx_done), 32'd0);
        chk("rst_frm_err", 32'(frm_err), 32'd0);
        repeat (5) @(negedge clk);

        prev_rises = 0;
        for (int i = 0; i < 10; i++) begin
            repeat (vecs[i].gap) @(negedge clk);
            send_byte(vecs[i].data, vecs[i].stop);
            chk($sformatf("vec%0d_cmd", i), 32'(bus.cmd), 32'(vecs[i].exp_cmd));
            chk($sformatf("vec%0d_rdy", i), 32'(bus.cmd_rdy), 32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_frm", i), 32'(frm_cnt), 32'(vecs[i].exp_frm));
            chk($sformatf("vec%0d_rises", i), 32'(rises), 32'(vecs[i].exp_rises));
            if (vecs[i].exp_rises > prev_rises) begin
                lat = int'((t_rise - t_start) / 10);
                chk($sformatf("vec%0d_latency_in_window", i), 32'(lat >= 152 && lat <= 160), 32'd1);
            end
            prev_rises = vecs[i].exp_rises;
        end

        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_frm", 32'(frm_cnt), 32'd2);
        chk("glitch_rdy", 32'(bus.cmd_rdy), 32'd1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h99, 1'b1);
        chk("after_glitch_cmd", 32'(bus.cmd), 32'h6699);
        chk("after_glitch_rdy", 32'(bus.cmd_rdy), 32'd1);

        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        chk("clr_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("clr_cmd_kept", 32'(bus.cmd), 32'h6699);
        send_byte(8'h20, 1'b1);
        chk("hi_rdy_low", 32'(bus.cmd_rdy), 32'd0);
        send_byte(8'h00, 1'b1);
        chk("cmd_2000", 32'(bus.cmd), 32'h2000);
        chk("rdy_2000", 32'(bus.cmd_rdy), 32'd1);

        send_byte(8'h5B, 1'b1);
        bus.clr_cmd_rdy = 1'b1;
        ok = 1'b0;
        fork
            send_byte(8'hC3, 1'b1);
            begin
                for (int n = 0; n < 400 && !ok; n++) begin
                    @(negedge clk);
                    if (bus.cmd_rdy) begin
                        bus.clr_cmd_rdy = 1'b0;
                        ok = 1'b1;
                    end
                end
            end
        join
        bus.clr_cmd_rdy = 1'b0;
        chk("set_beats_clr_seen", 32'(ok), 32'd1);
        chk("set_beats_clr_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("set_beats_clr_cmd", 32'(bus.cmd), 32'h5BC3);

        tx_check(RESP_ACK, 1'b1);

        send_byte(8'h11, 1'b1);
        fork
            send_byte(8'h3C, 1'b1);
            begin
                bus.resp = 8'h00;
                bus.trmt = 1'b1;
                @(negedge clk);
                bus.trmt = 1'b0;
                repeat (79) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("midrst_TX", 32'(TX), 32'd1);
                chk("midrst_cmd", 32'(bus.cmd), 32'd0);
                chk("midrst_rdy", 32'(bus.cmd_rdy), 32'd0);
                chk("midrst_tx_done", 32'(bus.tx_done), 32'd0);
                chk("midrst_frm_err", 32'(frm_err), 32'd0);
            end
        join
        repeat (600) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h5A, 1'b1);
        chk("post_rst_cmd", 32'(bus.cmd), 32'h5A5A);
        chk("post_rst_rdy", 32'(bus.cmd_rdy), 32'd1);

        pending = 1'b0; pend_b = 8'h00;
        exp_cmd = 16'h5A5A; exp_rdy = 1'b1;
        exp_frm = 0; exp_rises = 0;
        repeat (4) @(negedge clk);
        frm_base = frm_cnt; rise_base = rises;
        for (int it = 0; it < 24; it++) begin
            b     = 8'($urandom);
            bad   = ($urandom_range(0, 5) == 0);
            big   = ($urandom_range(0, 4) == 0);
            gap   = big ? int'($urandom_range(300, 360)) : int'($urandom_range(0, 40));
            do_tx = ($urandom_range(0, 2) == 0);
            txb   = 8'($urandom);
            repeat (gap) @(negedge clk);
            fork
                send_byte(b, ~bad);
                begin
                    if (do_tx) tx_check(txb, 1'b0);
                end
            join
            if (bad) begin
                pending = 1'b0;
                exp_frm++;
            end else if (pending && !big) begin
                exp_cmd = {pend_b, b};
                if (!exp_rdy) exp_rises++;
                exp_rdy = 1'b1;
                pending = 1'b0;
            end else begin
                pending = 1'b1;
                pend_b  = b;
                exp_rdy = 1'b0;
            end
            chk($sformatf("rand%0d_cmd", it), 32'(bus.cmd), 32'(exp_cmd));
            chk($sformatf("rand%0d_rdy", it), 32'(bus.cmd_rdy), 32'(exp_rdy));
            if ($urandom_range(0, 3) == 0) begin
                bus.clr_cmd_rdy = 1'b1;
                @(negedge clk);
                bus.clr_cmd_rdy = 1'b0;
                exp_rdy = 1'b0;
                @(negedge clk);
                chk($sformatf("rand%0d_clr", it), 32'(bus.cmd_rdy), 32'd0);
            end
        end
        repeat (4) @(negedge clk);
        chk("rand_frm_count", 32'(frm_cnt - frm_base), 32'(exp_frm));
        chk("rand_rise_count", 32'(rises - rise_base), 32'(exp_rises));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
